// File: rtl/gate_unit_pkg.sv
// Shared definitions for the gate-unit arbiter: opcode map and FSM state encoding.
package gate_unit_pkg;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NAND  = 3'b011;
  localparam logic [2:0] OP_NOR   = 3'b100;
  localparam logic [2:0] OP_XNOR  = 3'b101;
  localparam logic [2:0] OP_NOTA  = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } gu_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [ID_W-1:0]    idx_o
);

  logic              found;
  int unsigned       cand;
  logic [ID_W-1:0]   cand_idx;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand     = (int'(ptr_i) + off) % NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found              = 1'b1;
        onehot_o[cand_idx] = 1'b1;
        idx_o              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin front end sharing one registered bitwise logic unit between
// NUM_REQ requesters; results come back tagged with the owner's index.
module gate_unit_arbiter
  import gate_unit_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [3*NUM_REQ-1:0]     op_in,
  input  logic [WIDTH*NUM_REQ-1:0] a_in,
  input  logic [WIDTH*NUM_REQ-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid,
  output logic [ID_W-1:0]          y_id,
  output logic                     busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("gate_unit_arbiter: NUM_REQ must be in 2..8");
  end

  function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_NOTA:  r = ~a;
      OP_PASSA: r = a;
      default:  r = '0;
    endcase
    return r;
  endfunction

  gu_state_e          state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [ID_W-1:0]    y_id_q, y_id_d;
  logic               y_valid_q, y_valid_d;

  logic [NUM_REQ-1:0] win_onehot;
  logic [ID_W-1:0]    win_idx;
  logic [2:0]         op_sel;
  logic [WIDTH-1:0]   a_sel, b_sel;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (win_onehot),
    .idx_o    (win_idx)
  );

  // One-hot mux of the winner's slices; loop index keeps part-selects constant.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        op_sel = op_in[3*i +: 3];
        a_sel  = a_in[WIDTH*i +: WIDTH];
        b_sel  = b_in[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    y_d       = y_q;
    y_id_d    = y_id_q;
    y_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = win_onehot;
          op_d    = op_sel;
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = win_idx;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        y_d       = gate_eval(op_q, a_q, b_q);
        y_id_d    = id_q;
        ptr_d     = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        y_valid_d = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      y_q       <= '0;
      y_id_q    <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      y_q       <= y_d;
      y_id_q    <= y_id_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_id    = y_id_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter (NUM_REQ=4, WIDTH=8); inputs and
// samples are taken on the falling clock edge.
module tb_gate_unit_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned ID_W    = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [3*NUM_REQ-1:0]     op_in;
  logic [WIDTH*NUM_REQ-1:0] a_in;
  logic [WIDTH*NUM_REQ-1:0] b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         y;
  logic                     y_valid;
  logic [ID_W-1:0]          y_id;
  logic                     busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] sweep_y [8];
  logic [3:0] rr_gnt  [5];

  gate_unit_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .ID_W    (ID_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op_in   (op_in),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid),
    .y_id    (y_id),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int unsigned i, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] b);
    op_in[3*i +: 3]         = op;
    a_in[WIDTH*i +: WIDTH]  = a;
    b_in[WIDTH*i +: WIDTH]  = b;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},  32'(gnt),     32'h0);
    chk({tag, "_y"},    32'(y),       32'h0);
    chk({tag, "_yv"},   32'(y_valid), 32'h0);
    chk({tag, "_yid"},  32'(y_id),    32'h0);
    chk({tag, "_busy"}, 32'(busy),    32'h0);
  endtask

  initial begin
    sweep_y = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};
    rr_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1; req = '0; op_in = '0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    // single AND from requester 0
    load(0, 3'b000, 8'hF0, 8'h3C); req = 4'b0001;
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_yv_early", 32'(y_valid), 32'h0);
    req = '0;
    @(negedge clk);
    chk("single_yv", 32'(y_valid), 32'h1);
    chk("single_y", 32'(y), 32'h30);
    chk("single_yid", 32'(y_id), 32'h0);
    chk("single_gnt_pulse", 32'(gnt), 32'h0);
    @(negedge clk);
    chk("single_yv_drop", 32'(y_valid), 32'h0);
    chk("single_idle", 32'(busy), 32'h0);
    chk("single_y_hold", 32'(y), 32'h30);

    // opcode sweep on requester 2
    for (int k = 0; k < 8; k++) begin
      load(2, 3'(k), 8'hA5, 8'h0F); req = 4'b0100;
      @(negedge clk);
      chk("sweep_gnt", 32'(gnt), 32'h4);
      req = '0;
      @(negedge clk);
      chk("sweep_yv", 32'(y_valid), 32'h1);
      chk("sweep_y", 32'(y), 32'(sweep_y[k]));
      chk("sweep_yid", 32'(y_id), 32'h2);
      @(negedge clk);
    end

    // mid-cycle reset clears held y/y_id immediately and rewinds the pointer
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) load(i, 3'b111, 8'(8'h10 + i), 8'h00);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(rr_gnt[k]));
      chk("rr_yv_early", 32'(y_valid), 32'h0);
      if (k == 4) req = '0;
      @(negedge clk);
      chk("rr_yv", 32'(y_valid), 32'h1);
      chk("rr_yid", 32'(y_id), 32'(k % 4));
      chk("rr_y", 32'(y), 32'(8'h10 + k % 4));
      @(negedge clk);
      chk("rr_gap_gnt", 32'(gnt), 32'h0);
      chk("rr_gap_busy", 32'(busy), 32'h0);
    end

    // requester 3 served last, then 0 and 3 compete: 0 first, then 3
    req = 4'b1000;
    @(negedge clk);
    chk("fair_pre_gnt", 32'(gnt), 32'h8);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    chk("fair_gnt0", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("fair_yid0", 32'(y_id), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("fair_gnt3", 32'(gnt), 32'h8);
    req = '0;
    @(negedge clk);
    chk("fair_yid3", 32'(y_id), 32'h3);
    @(negedge clk);

    // move the pointer to 1, then abort requester 1 during EVAL
    load(0, 3'b111, 8'h77, 8'h00); req = 4'b0001;
    @(negedge clk);
    chk("abort_pre_gnt", 32'(gnt), 32'h1);
    req = '0;
    @(negedge clk);
    chk("abort_pre_y", 32'(y), 32'h77);
    @(negedge clk);
    load(1, 3'b000, 8'hFF, 8'hFF); req = 4'b0010;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 32'h2);
    chk("abort_busy", 32'(busy), 32'h1);
    req = '0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_yv", 32'(y_valid), 32'h0);
      chk("abort_y_zero", 32'(y), 32'h0);
    end

    load(0, 3'b111, 8'h66, 8'h00); req = 4'b0011;
    @(negedge clk);
    chk("post_abort_gnt0", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("post_abort_y0", 32'(y), 32'h66);
    @(negedge clk);
    @(negedge clk);
    chk("post_abort_gnt1", 32'(gnt), 32'h2);
    req = '0;
    @(negedge clk);
    chk("post_abort_yv1", 32'(y_valid), 32'h1);
    chk("post_abort_y1", 32'(y), 32'hFF);
    chk("post_abort_yid1", 32'(y_id), 32'h1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
